uart_rx_8n1: RTL and testbench



---
 rtl/uart_rx_8n1_if.sv | 17 +
 rtl/uart_rx_8n1.sv | 147 ++++++++++++++
 tb/tb_uart_rx_8n1.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_8n1_if.sv
// Receiver-side bundle for the 8N1 UART receiver.
//   rx   : serial line into the receiver (idle high)
//   data : last correctly received byte
//   rcv  : one-cycle strobe, data updated this cycle
//   ferr : one-cycle strobe, stop bit sampled low
//   busy : a frame is being received
// master drives the line and watches the results; slave is the receiver.
interface uart_rx_8n1_if;
    logic       rx;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;
    logic       busy;

    modport master (output rx, input data, rcv, ferr, busy);
    modport slave  (input rx, output data, rcv, ferr, busy);
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronises rx, samples each bit at its centre and
// presents the byte with a one-cycle strobe, or flags a framing error.
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : uart_rx_8n1_if.slave (rx in; data, rcv, ferr, busy out)
// BAUD is the number of clk cycles per bit (>= 4).
module uart_rx_8n1 #(
    parameter int unsigned BAUD = 104
) (
    input  logic         clk,
    input  logic         rstn,
    uart_rx_8n1_if.slave bus
);
    localparam int unsigned HALF = BAUD / 2;
    localparam int unsigned CW   = $clog2(BAUD);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } state_t;

    state_t        state, state_n;
    logic          rx_meta, rxs;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    data_q, data_n;
    logic          rcv_q, rcv_n;
    logic          ferr_q, ferr_n;
    logic          busy_q, busy_n;
    logic          expired;

    assign expired  = (cnt == '0);
    assign bus.data = data_q;
    assign bus.rcv  = rcv_q;
    assign bus.ferr = ferr_q;
    assign bus.busy = busy_q;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rxs     <= rx_meta;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            data_q <= '0;
            rcv_q  <= 1'b0;
            ferr_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            data_q <= data_n;
            rcv_q  <= rcv_n;
            ferr_q <= ferr_n;
            busy_q <= busy_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        data_n   = data_q;
        rcv_n    = 1'b0;
        ferr_n   = 1'b0;

        unique case (state)
            IDLE: begin
                // First low sample: wait half a bit to land on the start-bit centre.
                if (!rxs) begin
                    state_n = START;
                    cnt_n   = CW'(HALF - 1);
                end
            end
            START: begin
                if (!expired) begin
                    cnt_n = cnt - CW'(1);
                end else if (rxs) begin
                    // Line went back high before mid-start: treat as a glitch.
                    state_n = IDLE;
                end else begin
                    state_n  = DATA;
                    cnt_n    = CW'(BAUD - 1);
                    bitcnt_n = '0;
                end
            end
            DATA: begin
                if (!expired) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    // LSB arrives first, so shift in from the top.
                    shreg_n = {rxs, shreg[7:1]};
                    cnt_n   = CW'(BAUD - 1);
                    if (bitcnt == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bitcnt_n = bitcnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!expired) begin
                    cnt_n = cnt - CW'(1);
                end else if (rxs) begin
                    // Back to IDLE at mid-stop so a following start bit is not missed.
                    data_n  = shreg;
                    rcv_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    ferr_n  = 1'b1;
                    state_n = WAITHI;
                end
            end
            WAITHI: begin
                // Break or stuck-low line: hold off until it returns high.
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end
endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: two instances (BAUD=104 and BAUD=8) fed by an
// ideal 8N1 line model, checked with a vector table, hand-written corner
// sequences and randomised frames against a frame-level reference model.
module tb_uart_rx_8n1;
    localparam int unsigned BA = 104;
    localparam int unsigned BB = 8;

    logic clk = 1'b0;
    logic rstn_a;
    logic rstn_b;
    always #5 clk = ~clk;

    uart_rx_8n1_if if_a ();
    uart_rx_8n1_if if_b ();

    uart_rx_8n1 #(.BAUD(BA)) dut_a (.clk(clk), .rstn(rstn_a), .bus(if_a.slave));
    uart_rx_8n1 #(.BAUD(BB)) dut_b (.clk(clk), .rstn(rstn_b), .bus(if_b.slave));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] rcv_w, ferr_w, busy_w;
    logic [7:0] data_w [2];
    assign rcv_w     = {if_b.rcv, if_a.rcv};
    assign ferr_w    = {if_b.ferr, if_a.ferr};
    assign busy_w    = {if_b.busy, if_a.busy};
    assign data_w[0] = if_a.data;
    assign data_w[1] = if_b.data;

    // Event log plus strobe invariants, sampled on the falling edge.
    int         rcv_cnt  [2] = '{0, 0};
    int         ferr_cnt [2] = '{0, 0};
    int         last_cyc [2] = '{0, 0};
    logic [1:0] prev_rcv  = 2'b00;
    logic [1:0] prev_ferr = 2'b00;
    int         inv_err   = 0;

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rcv_w[s] === 1'b1) begin
                rcv_cnt[s]  = rcv_cnt[s] + 1;
                last_cyc[s] = cyc;
            end
            if (ferr_w[s] === 1'b1) ferr_cnt[s] = ferr_cnt[s] + 1;
            if (rcv_w[s] === 1'b1 && ferr_w[s] === 1'b1) begin
                inv_err = inv_err + 1;
                $display("FAIL strobe_overlap dut%0d at cycle %0d: rcv and ferr both 1, required exclusive", s, cyc);
            end
            if ((rcv_w[s] === 1'b1 && prev_rcv[s]) || (ferr_w[s] === 1'b1 && prev_ferr[s])) begin
                inv_err = inv_err + 1;
                $display("FAIL strobe_width dut%0d at cycle %0d: strobe high 2 cycles, required 1", s, cyc);
            end
        end
        prev_rcv  = rcv_w;
        prev_ferr = ferr_w;
    end

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input int s, input logic b);
        if (s == 0) if_a.rx = b;
        else        if_b.rx = b;
    endtask

    // Ideal transmitter: start, 8 data bits LSB first, stop; t0 is the edge index
    // right before the start bit appears on the line.
    task automatic send_frame(input int s, input logic [7:0] v, input logic stop,
                              input int per, output int t0);
        logic [9:0] f;
        f  = {stop, v, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            set_rx(s, f[i]);
            tick(per);
        end
    endtask

    function automatic int exp_latency(input int baud);
        return 3 + baud / 2 + 9 * baud;
    endfunction

    task automatic run_frame(input string tag, input int s, input logic [7:0] v,
                             input logic stop, input int per, input int hold,
                             input int gap, input logic [7:0] exp_data,
                             input logic exp_rcv, input logic exp_ferr,
                             input logic chk_lat);
        int t0, r0, f0, baud;
        baud = (s == 0) ? int'(BA) : int'(BB);
        r0   = rcv_cnt[s];
        f0   = ferr_cnt[s];
        send_frame(s, v, stop, per, t0);
        check({tag, " rcv_count"}, 32'(rcv_cnt[s] - r0), 32'(exp_rcv));
        check({tag, " ferr_count"}, 32'(ferr_cnt[s] - f0), 32'(exp_ferr));
        check({tag, " data"}, 32'(data_w[s]), 32'(exp_data));
        check({tag, " busy_end"}, 32'(busy_w[s]), 32'(exp_ferr));
        if (chk_lat && exp_rcv)
            check({tag, " latency"}, 32'(last_cyc[s] - t0), 32'(exp_latency(baud)));
        if (hold > 0) begin
            tick(hold);
            check({tag, " busy_hold"}, 32'(busy_w[s]), 32'(1));
            check({tag, " ferr_hold"}, 32'(ferr_cnt[s] - f0), 32'(1));
        end
        set_rx(s, 1'b1);
        tick(gap);
        if (exp_ferr)
            check({tag, " busy_release"}, 32'(busy_w[s]), 32'(0));
    endtask

    typedef struct {
        int         s;
        logic [7:0] v;
        logic       stop;
        int         per;
        int         hold;
        int         gap;
        logic [7:0] exp_data;
        logic       exp_rcv;
        logic       exp_ferr;
        logic       lat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int         pair_cyc;
        int         r0, f0, t0;
        logic [9:0] f;
        logic [7:0] model_b;
        logic [7:0] v;
        logic       stop;
        int         per, gap;

        //            s  v      stp per  hold gap exp    rcv  ferr lat
        tbl[0]  = '{0, 8'h55, 1'b1, 104, 0,  5, 8'h55, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{0, 8'h00, 1'b1, 101, 0,  3, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{0, 8'hFF, 1'b1, 107, 0,  3, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{0, 8'hA5, 1'b1, 101, 0,  3, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{0, 8'hA5, 1'b1, 107, 0,  0, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{0, 8'h00, 1'b1, 107, 0,  3, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{0, 8'hFF, 1'b1, 101, 0,  3, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1, 8'h00, 1'b1,   8, 0,  0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1, 8'hFF, 1'b1,   8, 0,  4, 8'hFF, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1, 8'h3C, 1'b1,   8, 0,  4, 8'h3C, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1, 8'hA5, 1'b0,   8, 50, 4, 8'h3C, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1, 8'h81, 1'b1,   8, 0,  4, 8'h81, 1'b1, 1'b0, 1'b1};

        // Reset state of both instances.
        if_a.rx = 1'b1;
        if_b.rx = 1'b1;
        rstn_a  = 1'b0;
        rstn_b  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset%0d data", s), 32'(data_w[s]), 32'(0));
            check($sformatf("reset%0d rcv", s),  32'(rcv_w[s]),  32'(0));
            check($sformatf("reset%0d ferr", s), 32'(ferr_w[s]), 32'(0));
            check($sformatf("reset%0d busy", s), 32'(busy_w[s]), 32'(0));
        end
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        tick(3);

        // Directed vector table.
        pair_cyc = 0;
        for (int i = 0; i < 12; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].s, tbl[i].v, tbl[i].stop, tbl[i].per,
                      tbl[i].hold, tbl[i].gap, tbl[i].exp_data, tbl[i].exp_rcv,
                      tbl[i].exp_ferr, tbl[i].lat);
            if (i == 7) pair_cyc = last_cyc[1];
            if (i == 8) check("back_to_back spacing", 32'(last_cyc[1] - pair_cyc), 32'(80));
        end

        // Short low glitch on BAUD=8: busy pulses, nothing is reported.
        r0 = rcv_cnt[1];
        f0 = ferr_cnt[1];
        set_rx(1, 1'b0);
        tick(2);
        set_rx(1, 1'b1);
        tick(2);
        check("glitch busy_pulse", 32'(busy_w[1]), 32'(1));
        tick(12);
        check("glitch busy_end", 32'(busy_w[1]), 32'(0));
        check("glitch rcv_count", 32'(rcv_cnt[1] - r0), 32'(0));
        check("glitch ferr_count", 32'(ferr_cnt[1] - f0), 32'(0));
        check("glitch data", 32'(data_w[1]), 32'(8'h81));

        // Reset during bit 4 of 0xC3, released with the line idle, then 0x7E.
        r0 = rcv_cnt[1];
        f  = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 6; i++) begin
            set_rx(1, f[i]);
            tick((i < 5) ? 8 : 4);
        end
        rstn_b = 1'b0;
        #1;
        check("midreset data", 32'(data_w[1]), 32'(0));
        check("midreset busy", 32'(busy_w[1]), 32'(0));
        check("midreset rcv",  32'(rcv_w[1]),  32'(0));
        check("midreset ferr", 32'(ferr_w[1]), 32'(0));
        tick(4);
        for (int i = 6; i < 10; i++) begin
            set_rx(1, f[i]);
            tick(8);
        end
        set_rx(1, 1'b1);
        tick(5);
        rstn_b = 1'b1;
        tick(3);
        check("midreset no_strobe", 32'(rcv_cnt[1] - r0), 32'(0));
        run_frame("after_reset", 1, 8'h7E, 1'b1, 8, 0, 4, 8'h7E, 1'b1, 1'b0, 1'b1);

        // Random frames on BAUD=104 with transmitter error within +-3%.
        for (int n = 0; n < 20; n++) begin
            v   = 8'($urandom_range(255, 0));
            per = int'($urandom_range(107, 101));
            gap = int'($urandom_range(10, 0));
            run_frame($sformatf("rndA%0d", n), 0, v, 1'b1, per, 0, gap, v,
                      1'b1, 1'b0, per == 104);
        end

        // Random frames on BAUD=8, some with a bad stop bit; model keeps the last good byte.
        model_b = 8'h7E;
        for (int n = 0; n < 40; n++) begin
            v    = 8'($urandom_range(255, 0));
            stop = ($urandom_range(5, 0) != 0);
            gap  = stop ? int'($urandom_range(4, 0)) : int'($urandom_range(8, 4));
            if (stop) model_b = v;
            run_frame($sformatf("rndB%0d", n), 1, v, stop, 8, 0, gap, model_b,
                      stop, !stop, 1'b1);
        end

        tick(4);
        check("strobe invariants", 32'(inv_err), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
